// File: rtl/riscv_lsu_if.sv
// Bundle of every riscv_lsu signal apart from clock and reset.
// master: the LSU's own view. It drives the memory request and writeback/error outputs,
//         and consumes the instruction offer and the memory response.
// slave:  the surrounding pipeline/memory view, with every direction mirrored.
interface riscv_lsu_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_req_we;
  logic [2:0]  mem_req_size;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err;
  logic        illegal_err;
  logic        timeout_err;

  modport master (
    input  instr_valid, instr, rs1_data, rs2_data, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output instr_ready, mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_we, mem_req_size,
           wb_valid, wb_rd, wb_data, misalign_err, illegal_err, timeout_err
  );

  modport slave (
    output instr_valid, instr, rs1_data, rs2_data, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  instr_ready, mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_we, mem_req_size,
           wb_valid, wb_rd, wb_data, misalign_err, illegal_err, timeout_err
  );
endinterface

// File: rtl/riscv_lsu.sv
// RV32 load/store unit for LW/SW only.
// It accepts one instruction, issues one word-sized memory request, and for loads
// returns the data as a single writeback pulse.
// Optional feature macro: LSU_TIMEOUT_EN.
//   Defined:   a load waiting longer than TIMEOUT_CYCLES for its response is aborted
//              with a timeout_err pulse.
//   Undefined: the LSU waits for the response indefinitely and timeout_err is tied 0.
module riscv_lsu #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  riscv_lsu_if.master  lsu
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("riscv_lsu supports only XLEN=32");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("riscv_lsu needs TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_RSP = 2'd2, WB = 2'd3} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [4:0]        rd_q, rd_d;
  logic              we_q, we_d;
  logic              instr_ready_q, instr_ready_d;
  logic              req_valid_q, req_valid_d;
  logic              wb_valid_q, wb_valid_d;
  logic              illegal_q, illegal_d;
  logic              misalign_q, misalign_d;
  logic              timeout_q, timeout_d;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]     cnt_q, cnt_d;
`endif

  // Decode fields; bits [19:15] (rs1 index) are not needed because rs1 arrives already read.
  logic [6:0]        opcode_s;
  logic [2:0]        funct3_s;
  logic              is_lw_s, is_sw_s;
  logic [XLEN-1:0]   imm_i_s, imm_s_s, ea_s;
  logic              unused_ok;

  assign opcode_s  = lsu.instr[6:0];
  assign funct3_s  = lsu.instr[14:12];
  assign is_lw_s   = (opcode_s == 7'b0000011) && (funct3_s == 3'b010);
  assign is_sw_s   = (opcode_s == 7'b0100011) && (funct3_s == 3'b010);
  assign imm_i_s   = {{20{lsu.instr[31]}}, lsu.instr[31:20]};
  assign imm_s_s   = {{20{lsu.instr[31]}}, lsu.instr[31:25], lsu.instr[11:7]};
  assign ea_s      = lsu.rs1_data + (is_sw_s ? imm_s_s : imm_i_s);
  assign unused_ok = &{1'b0, lsu.instr[19:15]};

  // Next-state and next-output logic; all outputs come straight from flops.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rd_d       = rd_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = 1'b0;
    illegal_d  = 1'b0;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (lsu.instr_valid) begin
          if (!(is_lw_s || is_sw_s)) begin
            illegal_d = 1'b1;
          end else if (ea_s[1:0] != 2'b00) begin
            misalign_d = 1'b1;
          end else begin
            addr_d  = ea_s;
            wdata_d = is_sw_s ? lsu.rs2_data : 32'h0000_0000;
            we_d    = is_sw_s;
            rd_d    = is_sw_s ? 5'd0 : lsu.instr[11:7];
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (lsu.mem_req_ready) begin
          state_d = we_q ? IDLE : WAIT_RSP;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = REQ;
        end
      end
      WAIT_RSP: begin
        // A response on the expiry cycle is checked first, so it wins over the timeout.
        if (lsu.mem_rsp_valid) begin
          wb_data_d  = lsu.mem_rsp_rdata;
          wb_valid_d = (rd_q != 5'd0);
          state_d    = WB;
        end else begin
`ifdef LSU_TIMEOUT_EN
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d     = cnt_q + CW'(1);
          end
`else
          state_d = WAIT_RSP;
`endif
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    instr_ready_d = (state_d == IDLE);
    req_valid_d   = (state_d == REQ);
  end

  // State and output registers; reset leaves the unit idle and ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= 32'h0000_0000;
      wdata_q       <= 32'h0000_0000;
      we_q          <= 1'b0;
      rd_q          <= 5'd0;
      wb_data_q     <= 32'h0000_0000;
      wb_valid_q    <= 1'b0;
      instr_ready_q <= 1'b1;
      req_valid_q   <= 1'b0;
      illegal_q     <= 1'b0;
      misalign_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      rd_q          <= rd_d;
      wb_data_q     <= wb_data_d;
      wb_valid_q    <= wb_valid_d;
      instr_ready_q <= instr_ready_d;
      req_valid_q   <= req_valid_d;
      illegal_q     <= illegal_d;
      misalign_q    <= misalign_d;
      timeout_q     <= timeout_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  // Response-wait counter, cleared on entry to WAIT_RSP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign lsu.instr_ready   = instr_ready_q;
  assign lsu.mem_req_valid = req_valid_q;
  assign lsu.mem_req_addr  = addr_q;
  assign lsu.mem_req_wdata = wdata_q;
  assign lsu.mem_req_we    = we_q;
  assign lsu.mem_req_size  = 3'b010;
  assign lsu.wb_valid      = wb_valid_q;
  assign lsu.wb_rd         = rd_q;
  assign lsu.wb_data       = wb_data_q;
  assign lsu.illegal_err   = illegal_q;
  assign lsu.misalign_err  = misalign_q;
  assign lsu.timeout_err   = timeout_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu.
// The timeout scenario follows LSU_TIMEOUT_EN, with TIMEOUT_CYCLES set to 16.
module tb_riscv_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  riscv_lsu_if bus();
  riscv_lsu #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst_n(rst_n), .lsu(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  task automatic offer(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    bus.rs1_data    = a;
    bus.rs2_data    = b;
    tick();
    bus.instr_valid = 1'b0;
  endtask

  task automatic handshake();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = d;
    tick();
    bus.mem_rsp_valid = 1'b0;
  endtask

  initial begin
    bus.instr_valid = 1'b0; bus.instr = 32'h0; bus.rs1_data = 32'h0; bus.rs2_data = 32'h0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = 32'h0;
    #22;
    chk("rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_size", 32'(bus.mem_req_size), 32'd2);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_errs", 32'({bus.illegal_err, bus.misalign_err, bus.timeout_err}), 32'd0);
    chk("rst_addr", bus.mem_req_addr, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    // LW x5,8(x1), rs1=0x1000; response three cycles after the handshake.
    offer(enc_i(12'd8, 5'd1, 3'b010, 5'd5), 32'h0000_1000, 32'h0);
    chk("lw_req_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("lw_addr", bus.mem_req_addr, 32'h0000_1008);
    chk("lw_we", 32'(bus.mem_req_we), 32'd0);
    chk("lw_wdata", bus.mem_req_wdata, 32'h0);
    chk("lw_size", 32'(bus.mem_req_size), 32'd2);
    chk("lw_busy", 32'(bus.instr_ready), 32'd0);
    handshake();
    chk("lw_req_drop", 32'(bus.mem_req_valid), 32'd0);
    tick(); tick();
    chk("lw_no_wb_yet", 32'(bus.wb_valid), 32'd0);
    respond(32'hDEAD_BEEF);
    chk("lw_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("lw_wb_rd", 32'(bus.wb_rd), 32'd5);
    chk("lw_wb_data", bus.wb_data, 32'hDEAD_BEEF);
    tick();
    chk("lw_wb_pulse", 32'(bus.wb_valid), 32'd0);
    chk("lw_ready_back", 32'(bus.instr_ready), 32'd1);

    // SW x2,-4(x3): ready held low for 4 cycles, request must stay stable.
    offer(enc_s(12'hFFC, 5'd2, 5'd3), 32'h0000_2000, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      chk("sw_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("sw_addr", bus.mem_req_addr, 32'h0000_1FFC);
      chk("sw_wdata", bus.mem_req_wdata, 32'h1234_5678);
      chk("sw_we", 32'(bus.mem_req_we), 32'd1);
      tick();
    end
    handshake();
    chk("sw_idle_ready", 32'(bus.instr_ready), 32'd1);
    chk("sw_req_drop", 32'(bus.mem_req_valid), 32'd0);
    chk("sw_no_wb", 32'(bus.wb_valid), 32'd0);
    tick();
    chk("sw_no_wb2", 32'(bus.wb_valid), 32'd0);

    // Misaligned LW: rs1=0x1001, offset 0.
    offer(enc_i(12'd0, 5'd1, 3'b010, 5'd6), 32'h0000_1001, 32'h0);
    chk("mis_err", 32'(bus.misalign_err), 32'd1);
    chk("mis_no_ill", 32'(bus.illegal_err), 32'd0);
    chk("mis_no_req", 32'(bus.mem_req_valid), 32'd0);
    chk("mis_ready", 32'(bus.instr_ready), 32'd1);
    tick();
    chk("mis_pulse", 32'(bus.misalign_err), 32'd0);
    chk("mis_no_req2", 32'(bus.mem_req_valid), 32'd0);

    // Address wrap: 0xFFFFFFFC + 8 = 0x4, then a zero-wait response.
    offer(enc_i(12'd8, 5'd4, 3'b010, 5'd7), 32'hFFFF_FFFC, 32'h0);
    chk("wrap_addr", bus.mem_req_addr, 32'h0000_0004);
    chk("wrap_valid", 32'(bus.mem_req_valid), 32'd1);
    handshake();
    respond(32'hCAFE_F00D);
    chk("wrap_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("wrap_wb_rd", 32'(bus.wb_rd), 32'd7);
    chk("wrap_wb_data", bus.wb_data, 32'hCAFE_F00D);
    tick();

    // LB (funct3=000) is illegal; with a misaligned address illegal still wins.
    offer(enc_i(12'd0, 5'd1, 3'b000, 5'd5), 32'h0000_1001, 32'h0);
    chk("ill_err", 32'(bus.illegal_err), 32'd1);
    chk("ill_prio", 32'(bus.misalign_err), 32'd0);
    chk("ill_ready", 32'(bus.instr_ready), 32'd1);
    chk("ill_no_req", 32'(bus.mem_req_valid), 32'd0);
    tick();
    chk("ill_pulse", 32'(bus.illegal_err), 32'd0);

    // Stray response in IDLE and stray ready are ignored.
    bus.mem_req_ready = 1'b1;
    respond(32'h5555_AAAA);
    bus.mem_req_ready = 1'b0;
    chk("stray_rsp", 32'(bus.wb_valid), 32'd0);
    chk("stray_ready", 32'(bus.instr_ready), 32'd1);

    // LW x0 performs the access but yields no writeback.
    offer(enc_i(12'd0, 5'd1, 3'b010, 5'd0), 32'h0000_3000, 32'h0);
    chk("x0_req", 32'(bus.mem_req_valid), 32'd1);
    handshake();
    respond(32'h1111_2222);
    chk("x0_no_wb", 32'(bus.wb_valid), 32'd0);
    chk("x0_busy_wb", 32'(bus.instr_ready), 32'd0);
    tick();
    chk("x0_ready", 32'(bus.instr_ready), 32'd1);

    // Reset while waiting for a response.
    offer(enc_i(12'd0, 5'd1, 3'b010, 5'd9), 32'h0000_4000, 32'h0);
    handshake();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", 32'(bus.instr_ready), 32'd1);
    chk("mrst_req", 32'(bus.mem_req_valid), 32'd0);
    chk("mrst_addr", bus.mem_req_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    respond(32'h9999_8888);
    chk("mrst_no_wb", 32'(bus.wb_valid), 32'd0);
    tick();
    chk("mrst_no_wb2", 32'(bus.wb_valid), 32'd0);

    // Response timeout behaviour.
    offer(enc_i(12'd0, 5'd1, 3'b010, 5'd10), 32'h0000_5000, 32'h0);
    handshake();
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_wait", 32'({bus.timeout_err, bus.instr_ready}), 32'd0);
    end
    tick();
    chk("to_err", 32'(bus.timeout_err), 32'd1);
    chk("to_ready", 32'(bus.instr_ready), 32'd1);
    tick();
    chk("to_pulse", 32'(bus.timeout_err), 32'd0);
    respond(32'h7777_6666);
    chk("to_no_wb", 32'(bus.wb_valid), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("nto_wait", 32'({bus.timeout_err, bus.instr_ready}), 32'd0);
    end
    respond(32'h7777_6666);
    chk("nto_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("nto_wb_data", bus.wb_data, 32'h7777_6666);
    chk("nto_wb_rd", 32'(bus.wb_rd), 32'd10);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
